// File: rtl/pe_feeder.sv
// PE feeder: streams filter, ifmap and ipsum words from source memories into the
// PE input FIFOs and drains output psums from the PE into a sink memory.

module pe_feeder_chan #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_active,
  input  logic [CW-1:0] i_count,
  input  logic [AW-1:0] i_base,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic [DW-1:0] o_data,
  output logic          o_push,
  input  logic          i_full,
  output logic          o_complete
);

  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_pushed;
  logic          r_inflight;
  logic [1:0]    r_occ;
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [DW-1:0] r_buf [2];

  logic [1:0]    w_level;
  logic [CW-1:0] w_pushed_next;

  assign o_push = (r_occ != 2'd0) && !i_full;
  // Level seen by the read issuer counts this cycle's pop, so a full-rate stream
  // can keep one read in flight while the buffer holds one word.
  assign w_level       = r_occ + {1'b0, r_inflight} - {1'b0, o_push};
  assign o_rd_en       = i_active && (r_issued < i_count) && (w_level < 2'd2);
  assign o_rd_addr     = i_base + AW'(r_issued);
  assign o_data        = r_buf[r_rd_ptr];
  assign w_pushed_next = r_pushed + {{(CW-1){1'b0}}, o_push};
  assign o_complete    = (w_pushed_next == i_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issued   <= '0;
      r_pushed   <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else if (i_clear) begin
      r_issued   <= '0;
      r_pushed   <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      if (o_rd_en)    r_issued <= r_issued + 1'b1;
      if (o_push)     r_rd_ptr <= ~r_rd_ptr;
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      r_pushed   <= w_pushed_next;
      r_inflight <= o_rd_en;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, o_push};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_buf[gi] <= '0;
        end else if (!i_clear && r_inflight && (r_wr_ptr == gi[0])) begin
          r_buf[gi] <= i_rd_data;
        end
      end
    end
  endgenerate

endmodule

module pe_feeder #(
  parameter int DATA_WIDTH_IFMAP  = 16,
  parameter int DATA_WIDTH_FILTER = 64,
  parameter int DATA_WIDTH_PSUM   = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int CNT_WIDTH         = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         pe_enable,
  output logic                         pe_configure,
  input  logic [CNT_WIDTH-1:0]         n_filter,
  input  logic [CNT_WIDTH-1:0]         n_ifmap,
  input  logic [CNT_WIDTH-1:0]         n_ipsum,
  input  logic [CNT_WIDTH-1:0]         n_opsum,
  input  logic [ADDR_WIDTH-1:0]        filter_base,
  input  logic [ADDR_WIDTH-1:0]        ifmap_base,
  input  logic [ADDR_WIDTH-1:0]        ipsum_base,
  input  logic [ADDR_WIDTH-1:0]        opsum_base,
  output logic                         filter_rd_en,
  output logic [ADDR_WIDTH-1:0]        filter_rd_addr,
  input  logic [DATA_WIDTH_FILTER-1:0] filter_rd_data,
  output logic                         ifmap_rd_en,
  output logic [ADDR_WIDTH-1:0]        ifmap_rd_addr,
  input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_rd_data,
  output logic                         ipsum_rd_en,
  output logic [ADDR_WIDTH-1:0]        ipsum_rd_addr,
  input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_rd_data,
  output logic [DATA_WIDTH_FILTER-1:0] filter,
  output logic                         push_filter,
  input  logic                         filter_fifo_full,
  output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
  output logic                         push_ifmap,
  input  logic                         ifmap_fifo_full,
  output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
  output logic                         push_ipsum,
  input  logic                         ipsum_fifo_full,
  input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
  input  logic                         opsum_fifo_empty,
  output logic                         pop_opsum,
  output logic                         opsum_wr_en,
  output logic [ADDR_WIDTH-1:0]        opsum_wr_addr,
  output logic [DATA_WIDTH_PSUM-1:0]   opsum_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_FILTER, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_WIDTH-1:0]  r_n_filter, r_n_ifmap, r_n_ipsum, r_n_opsum;
  logic [ADDR_WIDTH-1:0] r_filter_base, r_ifmap_base, r_ipsum_base, r_opsum_base;
  logic [CNT_WIDTH-1:0]  r_written;

  logic w_start_job;
  logic w_filter_complete, w_ifmap_complete, w_ipsum_complete, w_opsum_complete;
  logic w_drain_active;
  logic [CNT_WIDTH-1:0] w_written_next;

  assign w_start_job = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_filter    <= '0;
      r_n_ifmap     <= '0;
      r_n_ipsum     <= '0;
      r_n_opsum     <= '0;
      r_filter_base <= '0;
      r_ifmap_base  <= '0;
      r_ipsum_base  <= '0;
      r_opsum_base  <= '0;
    end else if (w_start_job) begin
      r_n_filter    <= n_filter;
      r_n_ifmap     <= n_ifmap;
      r_n_ipsum     <= n_ipsum;
      r_n_opsum     <= n_opsum;
      r_filter_base <= filter_base;
      r_ifmap_base  <= ifmap_base;
      r_ipsum_base  <= ipsum_base;
      r_opsum_base  <= opsum_base;
    end
  end

  pe_feeder_chan #(.DW(DATA_WIDTH_FILTER), .AW(ADDR_WIDTH), .CW(CNT_WIDTH)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start_job),
    .i_active   (r_state == S_FILTER),
    .i_count    (r_n_filter),
    .i_base     (r_filter_base),
    .o_rd_en    (filter_rd_en),
    .o_rd_addr  (filter_rd_addr),
    .i_rd_data  (filter_rd_data),
    .o_data     (filter),
    .o_push     (push_filter),
    .i_full     (filter_fifo_full),
    .o_complete (w_filter_complete)
  );

  pe_feeder_chan #(.DW(DATA_WIDTH_IFMAP), .AW(ADDR_WIDTH), .CW(CNT_WIDTH)) u_ifmap (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start_job),
    .i_active   (r_state == S_STREAM),
    .i_count    (r_n_ifmap),
    .i_base     (r_ifmap_base),
    .o_rd_en    (ifmap_rd_en),
    .o_rd_addr  (ifmap_rd_addr),
    .i_rd_data  (ifmap_rd_data),
    .o_data     (ifmap),
    .o_push     (push_ifmap),
    .i_full     (ifmap_fifo_full),
    .o_complete (w_ifmap_complete)
  );

  pe_feeder_chan #(.DW(DATA_WIDTH_PSUM), .AW(ADDR_WIDTH), .CW(CNT_WIDTH)) u_ipsum (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start_job),
    .i_active   (r_state == S_STREAM),
    .i_count    (r_n_ipsum),
    .i_base     (r_ipsum_base),
    .o_rd_en    (ipsum_rd_en),
    .o_rd_addr  (ipsum_rd_addr),
    .i_rd_data  (ipsum_rd_data),
    .o_data     (ipsum),
    .o_push     (push_ipsum),
    .i_full     (ipsum_fifo_full),
    .o_complete (w_ipsum_complete)
  );

  assign w_drain_active   = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign pop_opsum        = w_drain_active && !opsum_fifo_empty && (r_written < r_n_opsum);
  assign opsum_wr_en      = pop_opsum;
  assign opsum_wr_addr    = r_opsum_base + ADDR_WIDTH'(r_written);
  // Gated so the sink bus stays quiet (and zero under reset) between writes.
  assign opsum_wr_data    = pop_opsum ? opsum : '0;
  assign w_written_next   = r_written + {{(CNT_WIDTH-1){1'b0}}, pop_opsum};
  assign w_opsum_complete = (w_written_next == r_n_opsum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_written <= '0;
    end else if (w_start_job) begin
      r_written <= '0;
    end else begin
      r_written <= w_written_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    pe_enable    = 1'b0;
    pe_configure = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_CONFIG;
      end
      S_CONFIG: begin
        pe_enable    = 1'b1;
        pe_configure = 1'b1;
        w_state_next = S_FILTER;
      end
      S_FILTER: begin
        pe_enable = 1'b1;
        if (w_filter_complete) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        pe_enable = 1'b1;
        if (w_ifmap_complete && w_ipsum_complete) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        pe_enable = 1'b1;
        if (w_opsum_complete) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: behavioural source memories, opsum FIFO model and
// a scoreboard of expected pushes/writes compared as the DUT produces them.

module tb_pe_feeder;

  localparam int DWI = 16;
  localparam int DWF = 64;
  localparam int DWP = 64;
  localparam int AW  = 10;
  localparam int CW  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  logic busy, done, pe_enable, pe_configure;
  logic [CW-1:0] n_filter, n_ifmap, n_ipsum, n_opsum;
  logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic filter_rd_en, ifmap_rd_en, ipsum_rd_en;
  logic [AW-1:0] filter_rd_addr, ifmap_rd_addr, ipsum_rd_addr;
  logic [DWF-1:0] filter_rd_data, filter;
  logic [DWI-1:0] ifmap_rd_data, ifmap;
  logic [DWP-1:0] ipsum_rd_data, ipsum;
  logic push_filter, push_ifmap, push_ipsum;
  logic filter_fifo_full, ifmap_fifo_full, ipsum_fifo_full;
  logic [DWP-1:0] opsum, opsum_wr_data;
  logic opsum_fifo_empty, pop_opsum, opsum_wr_en;
  logic [AW-1:0] opsum_wr_addr;

  pe_feeder dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pe_enable(pe_enable), .pe_configure(pe_configure),
    .n_filter(n_filter), .n_ifmap(n_ifmap), .n_ipsum(n_ipsum), .n_opsum(n_opsum),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .filter_rd_en(filter_rd_en), .filter_rd_addr(filter_rd_addr), .filter_rd_data(filter_rd_data),
    .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr), .ifmap_rd_data(ifmap_rd_data),
    .ipsum_rd_en(ipsum_rd_en), .ipsum_rd_addr(ipsum_rd_addr), .ipsum_rd_data(ipsum_rd_data),
    .filter(filter), .push_filter(push_filter), .filter_fifo_full(filter_fifo_full),
    .ifmap(ifmap), .push_ifmap(push_ifmap), .ifmap_fifo_full(ifmap_fifo_full),
    .ipsum(ipsum), .push_ipsum(push_ipsum), .ipsum_fifo_full(ipsum_fifo_full),
    .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty), .pop_opsum(pop_opsum),
    .opsum_wr_en(opsum_wr_en), .opsum_wr_addr(opsum_wr_addr), .opsum_wr_data(opsum_wr_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DWF-1:0] fmem(input logic [AW-1:0] a);
    return {16'hF117, 38'h0, a};
  endfunction
  function automatic logic [DWI-1:0] imem(input logic [AW-1:0] a);
    return {6'h2B, a};
  endfunction
  function automatic logic [DWP-1:0] pmem(input logic [AW-1:0] a);
    return {16'hC0DE, 38'h5, a};
  endfunction

  // Source memories: data valid one cycle after the read enable.
  always @(posedge clk) begin
    if (filter_rd_en) filter_rd_data <= fmem(filter_rd_addr);
    if (ifmap_rd_en)  ifmap_rd_data  <= imem(ifmap_rd_addr);
    if (ipsum_rd_en)  ipsum_rd_data  <= pmem(ipsum_rd_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Opsum first-word-fall-through FIFO model.
  logic [DWP-1:0] osrc [0:15];
  int osrc_wr = 0;
  int osrc_rd = 0;
  logic toggle_en = 1'b0;
  assign opsum            = osrc[osrc_rd % 16];
  assign opsum_fifo_empty = (osrc_rd == osrc_wr) || (toggle_en && cyc[0]);
  always @(posedge clk) if (pop_opsum) osrc_rd <= osrc_rd + 1;

  logic [DWF-1:0] q_f[$];
  logic [DWI-1:0] q_i[$];
  logic [DWP-1:0] q_p[$];
  logic [AW-1:0]  q_oa[$];
  logic [DWP-1:0] q_od[$];

  int f_reads = 0, i_reads = 0, p_reads = 0, done_total = 0, done_cyc = 0;
  int f_last = -10, f_run = 0, i_last = -10, i_run = 0, p_last = -10, p_run = 0;
  int op_last = -10, if_out = 0;

  always @(negedge clk) begin
    f_reads += int'(filter_rd_en);
    i_reads += int'(ifmap_rd_en);
    p_reads += int'(ipsum_rd_en);
    if (push_filter) begin
      if (q_f.size() == 0) check("filter_extra_push", push_filter, 1'b0);
      else check("filter_data", filter, q_f.pop_front());
      if (f_last != cyc - 1) f_run = cyc;
      f_last = cyc;
    end
    if (push_ifmap) begin
      if (q_i.size() == 0) check("ifmap_extra_push", push_ifmap, 1'b0);
      else check("ifmap_data", ifmap, q_i.pop_front());
      if (i_last != cyc - 1) i_run = cyc;
      i_last = cyc;
    end
    if (push_ipsum) begin
      if (q_p.size() == 0) check("ipsum_extra_push", push_ipsum, 1'b0);
      else check("ipsum_data", ipsum, q_p.pop_front());
      if (p_last != cyc - 1) p_run = cyc;
      p_last = cyc;
    end
    if (opsum_wr_en) begin
      check("pop_vs_wr_en", pop_opsum, opsum_wr_en);
      check("pop_when_empty", opsum_fifo_empty, 1'b0);
      if (q_oa.size() == 0) check("opsum_extra_write", opsum_wr_en, 1'b0);
      else begin
        check("opsum_wr_addr", opsum_wr_addr, q_oa.pop_front());
        check("opsum_wr_data", opsum_wr_data, q_od.pop_front());
      end
      op_last = cyc;
    end
    if (!reset) if_out = 0;
    else begin
      if_out = if_out + int'(ifmap_rd_en) - int'(push_ifmap);
      if (ifmap_fifo_full) begin
        check("ifmap_outstanding_le2", if_out <= 2, 1'b1);
        check("ifmap_push_in_stall", push_ifmap, 1'b0);
      end
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int nf, input int ni, input int np, input int no,
                        input logic [AW-1:0] fb, input logic [AW-1:0] ib,
                        input logic [AW-1:0] pb, input logic [AW-1:0] ob);
    logic [AW-1:0] a;
    for (int i = 0; i < nf; i++) begin a = fb + AW'(i); q_f.push_back(fmem(a)); end
    for (int i = 0; i < ni; i++) begin a = ib + AW'(i); q_i.push_back(imem(a)); end
    for (int i = 0; i < np; i++) begin a = pb + AW'(i); q_p.push_back(pmem(a)); end
    for (int i = 0; i < no; i++) begin
      osrc[osrc_wr % 16] = {$urandom, $urandom};
      q_oa.push_back(ob + AW'(i));
      q_od.push_back(osrc[osrc_wr % 16]);
      osrc_wr++;
    end
    n_filter = CW'(nf); n_ifmap = CW'(ni); n_ipsum = CW'(np); n_opsum = CW'(no);
    filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("config_pe_configure", pe_configure, 1'b1);
    check("config_pe_enable", pe_enable, 1'b1);
    check("config_busy", busy, 1'b1);
    tick();
    check("configure_one_cycle", pe_configure, 1'b0);
    check("filter_pe_enable", pe_enable, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      tick();
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_in_done"}, busy, 1'b1);
    tick();
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_pe_enable"}, pe_enable, 1'b0);
    check({tag, "_pending"}, q_f.size() + q_i.size() + q_p.size() + q_oa.size(), 0);
  endtask

  int fr0, ir0, pr0, d0;

  initial begin
    reset = 1'b0; start = 1'b0;
    n_filter = '0; n_ifmap = '0; n_ipsum = '0; n_opsum = '0;
    filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
    filter_fifo_full = 1'b0; ifmap_fifo_full = 1'b0; ipsum_fifo_full = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pe_enable", pe_enable, 1'b0);
    check("rst_pe_configure", pe_configure, 1'b0);
    check("rst_rd_en", {filter_rd_en, ifmap_rd_en, ipsum_rd_en}, 3'b000);
    check("rst_push", {push_filter, push_ifmap, push_ipsum}, 3'b000);
    check("rst_opsum", {pop_opsum, opsum_wr_en, opsum_wr_addr, opsum_wr_data}, '0);
    reset = 1'b1;
    tick();
    $display("job filter4: n_filter=4 base=0x10");
    fr0 = f_reads;
    launch(4, 0, 0, 0, 10'h010, 10'h0, 10'h0, 10'h0);
    wait_done("filter4", 200);
    check("filter4_reads", f_reads - fr0, 4);
    check("filter4_consecutive", f_last - f_run, 3);
    check("filter4_done_latency", done_cyc - f_last, 3);

    $display("job ifmap_stall: n_ifmap=8 with full held 5 cycles");
    ir0 = i_reads;
    launch(0, 8, 0, 0, 10'h0, 10'h040, 10'h0, 10'h0);
    tick();
    ifmap_fifo_full = 1'b1;
    repeat (5) tick();
    ifmap_fifo_full = 1'b0;
    wait_done("ifmap_stall", 200);
    check("ifmap_stall_reads", i_reads - ir0, 8);

    $display("job concurrent: n_ifmap=6 n_ipsum=3");
    launch(0, 6, 3, 0, 10'h0, 10'h080, 10'h090, 10'h0);
    wait_done("concurrent", 200);
    check("concurrent_ifmap_rate", i_last - i_run, 5);
    check("concurrent_ipsum_rate", p_last - p_run, 2);
    check("concurrent_drain_after_ifmap", done_cyc - i_last, 2);

    $display("job opsum_wrap: n_opsum=5 base=0x3FE, empty toggling");
    toggle_en = 1'b1;
    launch(0, 0, 0, 5, 10'h0, 10'h0, 10'h0, 10'h3FE);
    wait_done("opsum_wrap", 200);
    toggle_en = 1'b0;
    check("opsum_done_after_last", done_cyc - op_last, 1);

    $display("job abort: reset during STREAM, then fresh job");
    d0 = done_total;
    launch(0, 20, 0, 0, 10'h0, 10'h100, 10'h0, 10'h0);
    repeat (6) tick();
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_enables", {pe_enable, pe_configure, done}, 3'b000);
    check("abort_ifmap_port", {ifmap_rd_en, push_ifmap, ifmap_rd_addr, ifmap}, '0);
    q_i.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    fr0 = f_reads; ir0 = i_reads;
    launch(2, 5, 0, 0, 10'h020, 10'h3FD, 10'h0, 10'h0);
    wait_done("after_abort", 200);
    check("after_abort_reads", {f_reads - fr0, i_reads - ir0}, {32'd2, 32'd5});
    check("abort_no_done", done_total - d0, 1);

    $display("job start_ignored: start pulsed in STREAM");
    d0 = done_total; ir0 = i_reads;
    launch(0, 10, 0, 0, 10'h0, 10'h150, 10'h0, 10'h0);
    repeat (2) tick();
    n_ifmap = 10'd3; ifmap_base = 10'h0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_ignored", 200);
    repeat (3) tick();
    check("start_ignored_reads", i_reads - ir0, 10);
    check("start_ignored_one_done", done_total - d0, 1);

    $display("job max_count: n_ipsum=1023 base=0x210");
    pr0 = p_reads;
    launch(0, 0, 1023, 0, 10'h0, 10'h0, 10'h210, 10'h0);
    wait_done("max_count", 3000);
    check("max_count_reads", p_reads - pr0, 1023);
    check("max_count_rate", p_last - p_run, 1022);

    $display("job zero: all counts 0");
    fr0 = f_reads; ir0 = i_reads; pr0 = p_reads;
    launch(0, 0, 0, 0, 10'h055, 10'h066, 10'h077, 10'h088);
    wait_done("zero", 50);
    check("zero_no_reads", {f_reads - fr0, i_reads - ir0, p_reads - pr0}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH_IFMAP 16 ifmap word; DATA_WIDTH_FILTER 64 filter word; DATA_WIDTH_PSUM 64 psum word; ADDR_WIDTH 10 source/sink memory address; CNT_WIDTH 10 word-count width.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 single clock, rising edge; reset in 1 asynchronous, active-low reset.
REQ-003 SHALL have control ports: start in 1 job launch pulse; busy out 1 job active; done out 1 one-cycle completion pulse; pe_enable out 1 PE clock-gate enable; pe_configure out 1 PE configure strobe.
REQ-004 SHALL have job ports, sampled on start in IDLE: n_filter, n_ifmap, n_ipsum, n_opsum in CNT_WIDTH word counts; filter_base, ifmap_base, ipsum_base, opsum_base in ADDR_WIDTH start addresses.
REQ-005 SHALL have per-channel X in {filter, ifmap, ipsum} source read ports: X_rd_en out 1; X_rd_addr out ADDR_WIDTH; X_rd_data in channel width, valid exactly one cycle after X_rd_en.
REQ-006 SHALL have PE push ports: X out channel width; push_X out 1; X_fifo_full in 1.
REQ-007 SHALL have opsum ports: opsum in DATA_WIDTH_PSUM (first-word-fall-through); opsum_fifo_empty in 1; pop_opsum out 1; opsum_wr_en out 1; opsum_wr_addr out ADDR_WIDTH; opsum_wr_data out DATA_WIDTH_PSUM.

Function
REQ-008 SHALL implement FSM states IDLE, CONFIG, FILTER, STREAM, DRAIN, DONE.
REQ-009 IDLE: start=1 -> latch counts/bases, go CONFIG; start ignored in all other states.
REQ-010 CONFIG: one cycle, pe_configure=1, pe_enable=1; -> FILTER.
REQ-011 pe_enable SHALL be 1 in CONFIG, FILTER, STREAM, DRAIN; 0 in IDLE, DONE.
REQ-012 FILTER: stream n_filter words; -> STREAM in the cycle after the last filter push.
REQ-013 STREAM: ifmap and ipsum channels stream concurrently and independently; opsum drain active; -> DRAIN once all ifmap and ipsum words pushed.
REQ-014 DRAIN: opsum drain only; -> DONE once n_opsum words written.
REQ-015 DONE: done=1 one cycle; -> IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Each source channel SHALL contain a 2-entry buffer; reads issued counter, pushes counter.
REQ-018 X_rd_en SHALL assert when channel active, issued < n_X, and (buffer occupancy + in-flight reads) < 2; addr = base + issued.
REQ-019 push_X SHALL assert when buffer non-empty and X_fifo_full=0; X = oldest entry; pop buffer same cycle.
REQ-020 Push and read return in the same cycle SHALL both take effect; no word dropped or duplicated.
REQ-021 Sustained throughput SHALL be one push per cycle per channel while full=0.
REQ-022 X_fifo_full=1 SHALL stall pushes without loss; reads stop once buffer plus in-flight reach 2.
REQ-023 pop_opsum = active (STREAM/DRAIN) AND opsum_fifo_empty=0 AND written < n_opsum.
REQ-024 opsum_wr_en = pop_opsum; opsum_wr_data = opsum; opsum_wr_addr = opsum_base + written, same cycle.
REQ-025 A count of zero SHALL complete its channel immediately (no reads, no pushes).
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 Counters SHALL be CNT_WIDTH bits; a count of 2^CNT_WIDTH-1 SHALL be fully served.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, clear counters and buffers, and drive all outputs 0.
REQ-029 reset asserted mid-job SHALL abort the job; no done pulse; after release, next start begins a fresh job.

Verification
REQ-030 n_filter=4, others 0, full=0, filter_base=0x10 -> pe_configure one cycle, reads 0x10..0x13, 4 consecutive pushes in order, done one cycle.
REQ-031 n_ifmap=8, ifmap_fifo_full held 1 cycles 3-7 -> all 8 words pushed exactly once in order, at most 2 reads outstanding during stall.
REQ-032 n_ifmap=6, n_ipsum=3 concurrent, no backpressure -> independent one-per-cycle pushes; DRAIN entered after the 6th ifmap push.
REQ-033 n_opsum=5, opsum_base=0x3FE, ADDR_WIDTH=10, empty toggling -> writes to 0x3FE, 0x3FF, 0x000, 0x001, 0x002 with matching data; done after 5th write.
REQ-034 reset=0 during STREAM -> busy=0, all outputs 0 immediately; new start after release runs a full job with correct addresses.
REQ-035 start pulsed in STREAM -> ignored; counts unchanged; exactly one done.
